// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: widths, FSM states and
// byte-address to word-index conversion.
package mem_responder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = DATA_W / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Upper bits are kept so callers can detect out-of-range addresses.
    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return 30'(addr >> 2);
    endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Word storage with two asynchronous read ports and one byte-masked
// synchronous write port.
module mem_responder_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                        clk,
    input  logic [DATA_W/8-1:0]         we,
    input  logic [$clog2(DEPTH)-1:0]    waddr,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [$clog2(DEPTH)-1:0]    raddr_a,
    output logic [DATA_W-1:0]           rdata_a,
    input  logic [$clog2(DEPTH)-1:0]    raddr_b,
    output logic [DATA_W-1:0]           rdata_b
);

    localparam int unsigned NL = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NL; i++) begin
            if (we[i]) begin
                mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the pipeline core: clears the array after reset, then
// serves combinational fetch/load and byte-masked stores with fault tracking.
module mem_responder #(
    parameter int unsigned DATA_W = mem_responder_pkg::DATA_W,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [31:0]           PcIn,
    output logic [31:0]           InstOut,
    input  logic [31:0]           RaddrIn,
    output logic [DATA_W-1:0]     MemDataOut,
    input  logic [31:0]           WaddrIn,
    input  logic [DATA_W-1:0]     WdataIn,
    input  logic [DATA_W/8-1:0]   WmaskIn,
    output logic                  Ready,
    output logic                  Fault,
    output logic [31:0]           FaultAddr,
    output logic [CNT_W-1:0]      LoadCount,
    output logic [CNT_W-1:0]      StoreCount
);

    import mem_responder_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NL = DATA_W / 8;

    state_e            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic              fault_q, fault_d;
    logic [31:0]       fault_addr_q, fault_addr_d;
    logic [CNT_W-1:0]  ld_cnt_q, ld_cnt_d;
    logic [CNT_W-1:0]  st_cnt_q, st_cnt_d;

    logic [29:0]       fetch_wi, load_wi, store_wi;
    logic              fetch_ok, load_ok, store_ok;
    logic              run, load_act, store_act;
    logic [NL-1:0]     arr_we;
    logic [AW-1:0]     arr_waddr;
    logic [DATA_W-1:0] arr_wdata, fetch_word, load_word;

    assign fetch_wi  = word_index(PcIn);
    assign load_wi   = word_index(RaddrIn);
    assign store_wi  = word_index(WaddrIn);
    assign fetch_ok  = (fetch_wi >> AW) == '0;
    assign load_ok   = (load_wi >> AW) == '0;
    assign store_ok  = (store_wi >> AW) == '0;
    assign run       = (state_q == RUN);
    assign load_act  = RaddrIn != '0;
    assign store_act = WmaskIn != '0;

    mem_responder_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (Clk),
        .we      (arr_we),
        .waddr   (arr_waddr),
        .wdata   (arr_wdata),
        .raddr_a (fetch_wi[AW-1:0]),
        .rdata_a (fetch_word),
        .raddr_b (load_wi[AW-1:0]),
        .rdata_b (load_word)
    );

    // Read side: fetch sees stored content only, load forwards the same-cycle store.
    always_comb begin
        InstOut    = '0;
        MemDataOut = '0;
        if (run) begin
            if (fetch_ok) begin
                InstOut = 32'(fetch_word);
            end
            if (load_ok) begin
                MemDataOut = load_word;
                if (store_act && store_ok && store_wi[AW-1:0] == load_wi[AW-1:0]) begin
                    for (int unsigned i = 0; i < NL; i++) begin
                        if (WmaskIn[i]) begin
                            MemDataOut[i*8 +: 8] = WdataIn[i*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        ld_cnt_d     = ld_cnt_q;
        st_cnt_d     = st_cnt_q;
        arr_we       = '0;
        arr_waddr    = store_wi[AW-1:0];
        arr_wdata    = WdataIn;
        case (state_q)
            CLEAR: begin
                arr_we    = '1;
                arr_waddr = ptr_q;
                arr_wdata = '0;
                ptr_d     = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (store_act && store_ok) begin
                    arr_we = WmaskIn;
                end
                if (load_act && ld_cnt_q != '1) begin
                    ld_cnt_d = ld_cnt_q + CNT_W'(1);
                end
                if (store_act && st_cnt_q != '1) begin
                    st_cnt_d = st_cnt_q + CNT_W'(1);
                end
                if (!fault_q) begin
                    if (store_act && !store_ok) begin
                        fault_d      = 1'b1;
                        fault_addr_d = WaddrIn;
                    end else if (load_act && !load_ok) begin
                        fault_d      = 1'b1;
                        fault_addr_d = RaddrIn;
                    end else if (!fetch_ok) begin
                        fault_d      = 1'b1;
                        fault_addr_d = PcIn;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= CLEAR;
            ptr_q        <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            ld_cnt_q     <= '0;
            st_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            ld_cnt_q     <= ld_cnt_d;
            st_cnt_q     <= st_cnt_d;
        end
    end

    assign Ready      = run;
    assign Fault      = fault_q;
    assign FaultAddr  = fault_addr_q;
    assign LoadCount  = ld_cnt_q;
    assign StoreCount = st_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected read data is queued when a
// cycle is driven and compared once the combinational outputs settle.
module tb_mem_responder;

    logic        Clk;
    logic        Rst;
    logic [31:0] PcIn, InstOut, RaddrIn, MemDataOut, WaddrIn, WdataIn;
    logic [3:0]  WmaskIn;
    logic        Ready, Fault;
    logic [31:0] FaultAddr;
    logic [15:0] LoadCount, StoreCount;

    logic [31:0] s_inst, s_data, s_faddr, s_waddr;
    logic [3:0]  s_wmask;
    logic        s_ready, s_fault;
    logic [3:0]  s_ld_cnt, s_st_cnt;

    mem_responder #(.DATA_W(32), .DEPTH(1024), .CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .PcIn(PcIn), .InstOut(InstOut),
        .RaddrIn(RaddrIn), .MemDataOut(MemDataOut), .WaddrIn(WaddrIn),
        .WdataIn(WdataIn), .WmaskIn(WmaskIn), .Ready(Ready), .Fault(Fault),
        .FaultAddr(FaultAddr), .LoadCount(LoadCount), .StoreCount(StoreCount)
    );

    mem_responder #(.DATA_W(32), .DEPTH(16), .CNT_W(4)) dut_sat (
        .Clk(Clk), .Rst(Rst), .PcIn(32'h0), .InstOut(s_inst),
        .RaddrIn(32'h0), .MemDataOut(s_data), .WaddrIn(s_waddr),
        .WdataIn(32'hA5A5A5A5), .WmaskIn(s_wmask), .Ready(s_ready), .Fault(s_fault),
        .FaultAddr(s_faddr), .LoadCount(s_ld_cnt), .StoreCount(s_st_cnt)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        string       tag;
        logic [31:0] inst;
        logic [31:0] data;
        bit          chk_data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [1024];
    bit          m_fault;
    logic [31:0] m_faddr;
    logic [15:0] m_ld, m_st;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return a < 32'h1000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] wm);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (wm[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) model[i] = 32'h0;
        m_fault = 1'b0;
        m_faddr = 32'h0;
        m_ld    = 16'h0;
        m_st    = 16'h0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_fault"}, {31'b0, Fault}, {31'b0, m_fault});
        check({tag, "_faddr"}, FaultAddr, m_faddr);
        check({tag, "_ldcnt"}, {16'b0, LoadCount}, {16'b0, m_ld});
        check({tag, "_stcnt"}, {16'b0, StoreCount}, {16'b0, m_st});
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic run_cycle(input string tag, input logic [31:0] pc, input logic [31:0] ra,
                             input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] wm);
        exp_t e;
        PcIn = pc; RaddrIn = ra; WaddrIn = wa; WdataIn = wd; WmaskIn = wm;
        e.tag      = tag;
        e.inst     = in_rng(pc) ? model[pc[11:2]] : 32'h0;
        e.chk_data = in_rng(ra);
        e.data     = in_rng(ra) ? model[ra[11:2]] : 32'h0;
        if (wm != 4'h0 && in_rng(wa) && in_rng(ra) && wa[11:2] == ra[11:2])
            e.data = merge(e.data, wd, wm);
        exp_q.push_back(e);
        if (ra != 32'h0 && m_ld != 16'hFFFF) m_ld++;
        if (wm != 4'h0 && m_st != 16'hFFFF) m_st++;
        if (!m_fault) begin
            if (wm != 4'h0 && !in_rng(wa)) begin m_fault = 1'b1; m_faddr = wa; end
            else if (ra != 32'h0 && !in_rng(ra)) begin m_fault = 1'b1; m_faddr = ra; end
            else if (!in_rng(pc)) begin m_fault = 1'b1; m_faddr = pc; end
        end
        #4;
        e = exp_q.pop_front();
        check({e.tag, "_inst"}, InstOut, e.inst);
        if (e.chk_data) check({e.tag, "_data"}, MemDataOut, e.data);
        @(posedge Clk); #1;
        if (wm != 4'h0 && in_rng(wa)) model[wa[11:2]] = merge(model[wa[11:2]], wd, wm);
        PcIn = 32'h0; RaddrIn = 32'h0; WaddrIn = 32'h0; WdataIn = 32'h0; WmaskIn = 4'h0;
    endtask

    // Releases reset and counts cycles until Ready, poking a store and an
    // out-of-range fetch late in the clear that must have no effect.
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        Rst = 1'b1;
        while (!Ready && n < 2000) begin
            if (n == 1000) begin
                PcIn = 32'h5000; RaddrIn = 32'h10; WaddrIn = 32'h10;
                WdataIn = 32'hFFFFFFFF; WmaskIn = 4'hF;
                #4;
                check({tag, "_clr_inst"}, InstOut, 32'h0);
                check({tag, "_clr_data"}, MemDataOut, 32'h0);
            end else begin
                PcIn = 32'h0; RaddrIn = 32'h0; WaddrIn = 32'h0; WdataIn = 32'h0; WmaskIn = 4'h0;
            end
            @(posedge Clk); #1;
            n++;
        end
        PcIn = 32'h0; RaddrIn = 32'h0; WaddrIn = 32'h0; WdataIn = 32'h0; WmaskIn = 4'h0;
        check({tag, "_ready_lat"}, 32'(n), 32'd1024);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'b0, Ready}, 32'h0);
        check({tag, "_inst"}, InstOut, 32'h0);
        check({tag, "_data"}, MemDataOut, 32'h0);
        check_status(tag);
    endtask

    initial begin
        Rst = 1'b0;
        PcIn = 32'h0; RaddrIn = 32'h0; WaddrIn = 32'h0; WdataIn = 32'h0; WmaskIn = 4'h0;
        s_waddr = 32'h0; s_wmask = 4'h0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        PcIn = 32'h20; RaddrIn = 32'h20;
        #1;
        check_reset_outputs("rst0");

        wait_clear("clr1");
        check_status("run_start");
        run_cycle("w4", 32'h0, 32'h10, 32'h0, 32'h0, 4'h0);
        run_cycle("st1", 32'h0, 32'h0, 32'h20, 32'hDEADBEEF, 4'hF);
        run_cycle("st2", 32'h0, 32'h0, 32'h20, 32'h0000AA00, 4'h2);
        run_cycle("ld20", 32'h20, 32'h20, 32'h0, 32'h0, 4'h0);
        check("ld20_const", model[8], 32'hDEADAAEF);
        run_cycle("byp", 32'h40, 32'h40, 32'h40, 32'h11223344, 4'h5);
        run_cycle("ld40", 32'h40, 32'h40, 32'h0, 32'h0, 4'h0);
        run_cycle("top", 32'hFFC, 32'hFFC, 32'hFFC, 32'h12345678, 4'hF);
        check_status("pre_fault");
        run_cycle("oor_st", 32'h0, 32'h0, 32'h1000, 32'hFFFFFFFF, 4'hF);
        check_status("oor_st");
        run_cycle("ld0", 32'h0, 32'h0, 32'h0, 32'h0, 4'h0);
        run_cycle("oor_ld", 32'h0, 32'h2000, 32'h0, 32'h0, 4'h0);
        check_status("oor_ld");
        run_cycle("ldffc", 32'h20, 32'hFFC, 32'h0, 32'h0, 4'h0);

        // Reset asserted in RUN
        Rst = 1'b0;
        PcIn = 32'h20; RaddrIn = 32'h20;
        model_reset();
        #1;
        check_reset_outputs("rst_run");
        @(posedge Clk); #1;
        wait_clear("clr2");
        run_cycle("post_rst", 32'h20, 32'h20, 32'h0, 32'h0, 4'h0);
        check_status("post_rst");
        run_cycle("prio", 32'h3000, 32'h2004, 32'h1008, 32'h0, 4'h1);
        check_status("prio");

        // Store counter saturation on the narrow-counter instance
        check("sat_ready", {31'b0, s_ready}, 32'h1);
        s_waddr = 32'h4;
        for (int i = 0; i < 20; i++) begin
            s_wmask = 4'h1;
            @(posedge Clk); #1;
        end
        check("sat_cnt", {28'b0, s_st_cnt}, 32'd15);
        @(posedge Clk); #1;
        s_wmask = 4'h0;
        check("sat_hold", {28'b0, s_st_cnt}, 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
